inputc_rx: RTL and testbench
============================

Name: inputc_rx

Overview:
- Receiver end of the router-to-router link. It accepts flits driven by the upstream router's output channel.
- Buffers flits in one FIFO per virtual channel (2 VCs). Presents the FIFO heads to the local switch/crossbar.
- Returns per-VC credit acks and per-VC lock status upstream. These feed the upstream credit counters and VC-lock logic.

Parameters:
- ROUTERID, 0, router identifier (debug/tracing only)
- PCHID, 0, physical channel identifier (debug/tracing only)
- DATAW, 32, flit width in bits; bits [DATAW-1:DATAW-2] are the flit type
- FIFOD, 4, per-VC FIFO depth in flits; must be >= 2 and a power of 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- idata  in  DATAW  flit from upstream link
- ivalid  in  1  flit valid this cycle
- ivch  in  1  target VC of idata
- oack  out  2  per-VC credit return, one-cycle pulse per dequeued flit
- olck  out  2  per-VC lock: VC holds or is receiving a packet
- odata0  out  DATAW  head flit of VC0 FIFO
- odata1  out  DATAW  head flit of VC1 FIFO
- ovalid  out  2  per-VC FIFO non-empty
- ideq  in  2  per-VC dequeue request from switch allocator
- oerr  out  1  sticky protocol/overflow error

Behaviour:
- Flit type encoding is 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 HEADTAIL. Type is only meaningful when ivalid=1.
- Reset (async, rst=1) clears all FIFO pointers and counts, pktopen[1:0], oack, olck and oerr. ovalid=0.
- odata0/odata1 are don't-care while the matching ovalid bit is 0. The bench must not check them then.
- Per-VC state: wr_ptr and rd_ptr, each log2(FIFOD) bits and wrapping modulo FIFOD. cnt is log2(FIFOD)+1 bits, range 0..FIFOD. pktopen is 1 bit.
- Write: at posedge, ivalid=1 and cnt[ivch]<FIFOD stores idata at wr_ptr[ivch], increments wr_ptr, and increments cnt.
- Overflow: ivalid=1 into a full VC drops the flit, sets oerr=1, and leaves pointers unchanged.
- Read: ovalid[n] = (cnt[n]!=0), combinational from the count register. odataN is the FIFO entry at rd_ptr[n], read asynchronously.
- ideq[n]=1 with ovalid[n]=1 pops the entry at posedge. ideq[n] while empty is ignored: no ack, no error.
- Simultaneous write and pop on the same VC: both occur and cnt is unchanged.
- No bypass: a flit written into an empty FIFO becomes visible (ovalid=1) the cycle after the write. Write-to-output latency is 1 cycle.
- Writes and pops on different VCs in the same cycle are independent.
- oack[n] is registered and equals "pop on VC n" from the previous cycle. It is exactly one pulse per popped flit and is never asserted for dropped flits.
- pktopen[n]:
  - Set on write of HEAD.
  - Cleared on write of TAIL.
  - Unchanged by HEADTAIL and BODY.
- Protocol errors set oerr=1 (sticky until reset); the flit is still stored if space exists:
  - Write of HEAD or HEADTAIL while pktopen=1.
  - Write of BODY or TAIL while pktopen=0.
- olck[n] is registered: next olck[n] = (next cnt[n]!=0) || (next pktopen[n]).
  - It rises the cycle after the first flit of a packet is written.
  - It falls the cycle after the last flit is popped, provided no further packet is open.
  - Upstream holds its VC lock while olck=1.
- Credit invariant: upstream credit count equals this block's cnt plus in-flight ack pulses. The block never generates acks beyond the number of flits written.

Test Plan:
- Reset then idle: assert rst mid-cycle (asynchronously) -> oack=00, olck=00, ovalid=00, oerr=0 immediately; nothing changes for 10 idle cycles.
- Single 4-flit packet to VC0 (HEAD, BODY, BODY, TAIL, one per cycle, ideq=00):
  - ovalid[0]=1 and olck[0]=1 from cycle 1; cnt0=4.
  - Then ideq=01 for 4 cycles -> odata0 returns the flits in order; oack[0] pulses 4 times, each one cycle after its pop.
  - olck[0]=0 the cycle after the 4th pop.
- Interleaved VCs: HEADTAIL to VC1 and HEAD to VC0 on consecutive cycles, then pop both in the same cycle -> oack=11 pulse; olck=01 afterwards, because VC0 pktopen=1.
- Full and overflow: write 5 flits to VC1 with FIFOD=4 and no pops -> the 5th is dropped, oerr=1, cnt1 stays 4; popping 4 gives exactly 4 acks.
- Simultaneous write and pop on a VC holding 2 flits -> cnt stays 2 and data order is preserved. Push pointers across wrap: 10 write/pop cycles -> all data correct.
- Protocol error: BODY to idle VC0 -> oerr=1, flit stored, ovalid[0]=1. Asserting rst mid-packet -> all state cleared and oerr=0.

Source files
------------

// File: rtl/inputc_rx_if.sv
// Router link receive port: upstream flit channel, credit/lock return,
// and per-VC FIFO heads facing the local switch.
interface inputc_rx_if #(
    parameter int DATAW = 32
);
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic             ivch;
    logic [1:0]       oack;
    logic [1:0]       olck;
    logic [DATAW-1:0] odata0;
    logic [DATAW-1:0] odata1;
    logic [1:0]       ovalid;
    logic [1:0]       ideq;
    logic             oerr;

    modport master (
        output idata, ivalid, ivch, ideq,
        input  oack, olck, odata0, odata1, ovalid, oerr
    );

    modport slave (
        input  idata, ivalid, ivch, ideq,
        output oack, olck, odata0, odata1, ovalid, oerr
    );
endinterface

// File: rtl/inputc_rx.sv
// Router input channel: two per-VC flit FIFOs with credit acks,
// VC lock status and sticky protocol/overflow error.
module inputc_rx #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int DATAW    = 32,
    parameter int FIFOD    = 4
) (
    input logic         clk,
    input logic         rst,
    inputc_rx_if.slave  bus
);
    localparam int AW = $clog2(FIFOD);
    localparam int CW = AW + 1;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    if (FIFOD < 2 || (FIFOD & (FIFOD - 1)) != 0 ||
        ROUTERID < 0 || PCHID < 0) begin : g_bad_param
        $error("inputc_rx: illegal parameters");
    end

    ptr_t wr_ptr_q [2];
    ptr_t wr_ptr_d [2];
    ptr_t rd_ptr_q [2];
    ptr_t rd_ptr_d [2];
    cnt_t cnt_q    [2];
    cnt_t cnt_d    [2];

    logic [1:0] pktopen_q, pktopen_d;
    logic [1:0] oack_q, oack_d;
    logic [1:0] olck_q, olck_d;
    logic       oerr_q, oerr_d;
    logic [1:0] wr_en, pop, hit;
    logic [1:0] ftype;

    logic [DATAW-1:0] mem_q [2][FIFOD];

    assign ftype = bus.idata[DATAW-1 -: 2];

    always_comb begin
        oerr_d    = oerr_q;
        pktopen_d = pktopen_q;
        wr_en     = '0;
        pop       = '0;
        hit       = '0;
        olck_d    = '0;
        for (int v = 0; v < 2; v++) begin
            hit[v]   = bus.ivalid && (bus.ivch == 1'(v));
            wr_en[v] = hit[v] && (cnt_q[v] != cnt_t'(FIFOD));
            pop[v]   = bus.ideq[v] && (cnt_q[v] != '0);
            // Framing is judged against the packet state seen before this flit.
            if (hit[v]) begin
                if (!wr_en[v]) oerr_d = 1'b1;
                unique case (ftype)
                    T_HEAD, T_HT:   if (pktopen_q[v]) oerr_d = 1'b1;
                    T_BODY, T_TAIL: if (!pktopen_q[v]) oerr_d = 1'b1;
                    default: ;
                endcase
            end
            if (wr_en[v] && ftype == T_HEAD) pktopen_d[v] = 1'b1;
            if (wr_en[v] && ftype == T_TAIL) pktopen_d[v] = 1'b0;
            wr_ptr_d[v] = wr_ptr_q[v] + ptr_t'(wr_en[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + ptr_t'(pop[v]);
            cnt_d[v]    = cnt_q[v] + cnt_t'(wr_en[v]) - cnt_t'(pop[v]);
            olck_d[v]   = (cnt_d[v] != '0) || pktopen_d[v];
        end
        oack_d = pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            pktopen_q <= '0;
            oack_q    <= '0;
            olck_q    <= '0;
            oerr_q    <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            pktopen_q <= pktopen_d;
            oack_q    <= oack_d;
            olck_q    <= olck_d;
            oerr_q    <= oerr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= bus.idata;
        end
    end

    assign bus.oack      = oack_q;
    assign bus.olck      = olck_q;
    assign bus.oerr      = oerr_q;
    assign bus.ovalid[0] = (cnt_q[0] != '0);
    assign bus.ovalid[1] = (cnt_q[1] != '0);
    assign bus.odata0    = mem_q[0][rd_ptr_q[0]];
    assign bus.odata1    = mem_q[1][rd_ptr_q[1]];
endmodule

// File: tb/tb_inputc_rx.sv
// Directed-vector bench for the router input channel.
module tb_inputc_rx;
    localparam int DATAW = 32;
    localparam int FIFOD = 4;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    inputc_rx_if #(.DATAW(DATAW)) bus ();

    inputc_rx #(
        .ROUTERID(0), .PCHID(0), .DATAW(DATAW), .FIFOD(FIFOD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] mk(input logic [1:0] t,
                                            input int p);
        return {t, 30'(p)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic ch,
                       input logic [DATAW-1:0] d, input logic [1:0] dq);
        bus.ivalid = v;
        bus.ivch   = ch;
        bus.idata  = d;
        bus.ideq   = dq;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, '0, 2'b00);
    endtask

    task automatic pulse_reset(input string tag);
        idle();
        #2 rst = 1'b1;
        #1;
        chk({tag, "_oack"}, 64'(bus.oack), 64'h0);
        chk({tag, "_olck"}, 64'(bus.olck), 64'h0);
        chk({tag, "_ovalid"}, 64'(bus.ovalid), 64'h0);
        chk({tag, "_oerr"}, 64'(bus.oerr), 64'h0);
        step();
        rst = 1'b0;
    endtask

    logic [DATAW-1:0] f [12];
    int acks;

    initial begin
        idle();
        step();

        // Reset then idle
        pulse_reset("rst0");
        for (int i = 0; i < 10; i++) step();
        chk("idle_oack", 64'(bus.oack), 64'h0);
        chk("idle_olck", 64'(bus.olck), 64'h0);
        chk("idle_ovalid", 64'(bus.ovalid), 64'h0);
        chk("idle_oerr", 64'(bus.oerr), 64'h0);

        // 4-flit packet to VC0
        f[0] = mk(HEAD, 'h101);
        f[1] = mk(BODY, 'h102);
        f[2] = mk(BODY, 'h103);
        f[3] = mk(TAIL, 'h104);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b0, f[i], 2'b00);
            step();
            chk("pkt_ovalid", 64'(bus.ovalid), 64'h1);
            chk("pkt_olck", 64'(bus.olck), 64'h1);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b0, '0, 2'b01);
            chk("pkt_odata0", 64'(bus.odata0), 64'(f[i]));
            step();
            chk("pkt_oack", 64'(bus.oack), 64'h1);
            chk("pkt_olck_pop", 64'(bus.olck), (i == 3) ? 64'h0 : 64'h1);
        end
        idle();
        step();
        chk("pkt_oack_end", 64'(bus.oack), 64'h0);
        chk("pkt_ovalid_end", 64'(bus.ovalid), 64'h0);
        chk("pkt_oerr", 64'(bus.oerr), 64'h0);

        // Interleaved VCs
        f[0] = mk(HT, 'h201);
        f[1] = mk(HEAD, 'h202);
        drv(1'b1, 1'b1, f[0], 2'b00);
        step();
        chk("il_ovalid_a", 64'(bus.ovalid), 64'h2);
        chk("il_olck_a", 64'(bus.olck), 64'h2);
        drv(1'b1, 1'b0, f[1], 2'b00);
        step();
        chk("il_ovalid_b", 64'(bus.ovalid), 64'h3);
        chk("il_olck_b", 64'(bus.olck), 64'h3);
        drv(1'b0, 1'b0, '0, 2'b11);
        chk("il_odata0", 64'(bus.odata0), 64'(f[1]));
        chk("il_odata1", 64'(bus.odata1), 64'(f[0]));
        step();
        chk("il_oack", 64'(bus.oack), 64'h3);
        chk("il_ovalid_c", 64'(bus.ovalid), 64'h0);
        chk("il_olck_c", 64'(bus.olck), 64'h1);
        drv(1'b1, 1'b0, mk(TAIL, 'h203), 2'b00);
        step();
        chk("il_oack_idle", 64'(bus.oack), 64'h0);
        drv(1'b0, 1'b0, '0, 2'b01);
        step();
        idle();
        step();
        chk("il_olck_end", 64'(bus.olck), 64'h0);
        chk("il_oerr", 64'(bus.oerr), 64'h0);

        // Full and overflow on VC1
        for (int i = 0; i < 5; i++) begin
            f[i] = mk(HT, 'h300 + i);
            drv(1'b1, 1'b1, f[i], 2'b00);
            step();
            chk("ov_oerr", 64'(bus.oerr), (i == 4) ? 64'h1 : 64'h0);
        end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, '0, 2'b10);
            if (i < 4) chk("ov_odata1", 64'(bus.odata1), 64'(f[i]));
            chk("ov_ovalid", 64'(bus.ovalid), (i < 4) ? 64'h2 : 64'h0);
            step();
            if (bus.oack[1]) acks++;
        end
        idle();
        step();
        if (bus.oack[1]) acks++;
        chk("ov_acks", 64'(acks), 64'd4);
        chk("ov_oerr_sticky", 64'(bus.oerr), 64'h1);

        // Concurrent write and pop across pointer wrap
        pulse_reset("rst1");
        chk("rst1_oerr_after", 64'(bus.oerr), 64'h0);
        for (int i = 0; i < 12; i++) f[i] = mk((i == 0) ? HEAD : BODY, 'h400 + i);
        drv(1'b1, 1'b0, f[0], 2'b00);
        step();
        drv(1'b1, 1'b0, f[1], 2'b00);
        step();
        for (int k = 0; k < 10; k++) begin
            drv(1'b1, 1'b0, f[k+2], 2'b01);
            chk("wp_odata0", 64'(bus.odata0), 64'(f[k]));
            step();
            chk("wp_oack", 64'(bus.oack), 64'h1);
        end
        for (int k = 10; k < 12; k++) begin
            drv(1'b0, 1'b0, '0, 2'b01);
            chk("wp_tail_ovalid", 64'(bus.ovalid), 64'h1);
            chk("wp_tail_odata0", 64'(bus.odata0), 64'(f[k]));
            step();
        end
        idle();
        step();
        chk("wp_ovalid_end", 64'(bus.ovalid), 64'h0);
        chk("wp_olck_open", 64'(bus.olck), 64'h1);
        chk("wp_oerr", 64'(bus.oerr), 64'h0);

        // Reset mid-packet, then framing error
        pulse_reset("rst2");
        step();
        chk("rst2_olck_after", 64'(bus.olck), 64'h0);
        f[0] = mk(BODY, 'h501);
        drv(1'b1, 1'b0, f[0], 2'b00);
        step();
        chk("pe_oerr", 64'(bus.oerr), 64'h1);
        chk("pe_ovalid", 64'(bus.ovalid), 64'h1);
        chk("pe_odata0", 64'(bus.odata0), 64'(f[0]));
        chk("pe_olck", 64'(bus.olck), 64'h1);
        drv(1'b0, 1'b0, '0, 2'b01);
        step();
        chk("pe_oack", 64'(bus.oack), 64'h1);
        chk("pe_olck_end", 64'(bus.olck), 64'h0);
        pulse_reset("rst3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
